// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the 16-bit ALU: snapshots register-file operands, holds the ALU
// inputs for EXEC_CYCLES cycles, then writes the result and flags back.
module alu_op_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [15:0] REG_INIT    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ld,
    input  logic [2:0]  in_opc,
    input  logic        in_cin,
    input  logic [1:0]  in_dst,
    input  logic [1:0]  in_srca,
    input  logic [1:0]  in_srcb,
    input  logic [15:0] in_imm,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_c,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_w,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic        done,
    output logic        err,
    output logic        flag_z,
    output logic        flag_n,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);
    localparam logic [2:0] OpcIllegal = 3'b111;

    state_e      state_q;
    logic [15:0] regs_q [4];
    logic [15:0] alu_a_q, alu_b_q;
    logic        alu_c_q;
    logic [2:0]  alu_opc_q;
    logic [1:0]  dst_q;
    logic [3:0]  cnt_q;
    logic        done_q, err_q, flag_z_q, flag_n_q;
    logic        accept;

    // in_ready decodes registered state only, so in_valid never reaches it combinationally.
    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            for (int i = 0; i < 4; i++) regs_q[i] <= REG_INIT;
            alu_a_q   <= 16'h0000;
            alu_b_q   <= 16'h0000;
            alu_c_q   <= 1'b0;
            alu_opc_q <= 3'b000;
            dst_q     <= 2'd0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (in_ld) begin
                            regs_q[in_dst] <= in_imm;
                            done_q         <= 1'b1;
                        end else if (in_opc == OpcIllegal) begin
                            err_q <= 1'b1;
                        end else begin
                            alu_a_q   <= regs_q[in_srca];
                            alu_b_q   <= regs_q[in_srcb];
                            alu_c_q   <= in_cin;
                            alu_opc_q <= in_opc;
                            dst_q     <= in_dst;
                            cnt_q     <= CntLoad;
                            state_q   <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == 4'd0) state_q <= StWb;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                StWb: begin
                    regs_q[dst_q] <= alu_w;
                    flag_z_q      <= alu_zer;
                    flag_n_q      <= alu_neg;
                    done_q        <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_c   = alu_c_q;
    assign alu_opc = alu_opc_q;
    assign done    = done_q;
    assign err     = err_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;
    assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios then random instructions against a reference
// model of the register file, flags and handshake timing.
module tb_alu_op_sequencer;

    localparam int unsigned EC = 3;
    localparam logic [15:0] RINIT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic        in_ld = 1'b0, in_cin = 1'b0;
    logic [2:0]  in_opc = 3'b000;
    logic [1:0]  in_dst = 2'd0, in_srca = 2'd0, in_srcb = 2'd0, rd_addr = 2'd0;
    logic [15:0] in_imm = 16'h0000;
    logic [15:0] alu_a, alu_b, alu_w, rd_data;
    logic        alu_c, alu_zer, alu_neg, done, err, flag_z, flag_n;
    logic [2:0]  alu_opc;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_reg [4];
    logic        m_fz, m_fn;

    always #5 clk = ~clk;

    alu_op_sequencer #(.EXEC_CYCLES(EC), .REG_INIT(RINIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld),
        .in_opc(in_opc), .in_cin(in_cin), .in_dst(in_dst), .in_srca(in_srca),
        .in_srcb(in_srcb), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_opc(alu_opc), .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg), .done(done),
        .err(err), .flag_z(flag_z), .flag_n(flag_n), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Stand-in combinational ALU driven by the sequencer.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        case (op)
            3'b000:  return 16'h0000 - a;
            3'b001:  return a - b;
            3'b010:  return a + b + {15'd0, c};
            3'b011:  return a | b;
            3'b100:  return a & b;
            3'b101:  return a ^ b;
            3'b110:  return {a[7:0], b[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_w   = alu_f(alu_opc, alu_a, alu_b, alu_c);
    assign alu_zer = (alu_w == 16'h0000);
    assign alu_neg = alu_w[15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk($sformatf("%s reg%0d", tag, i), {16'd0, rd_data}, {16'd0, m_reg[i]});
        end
        chk({tag, " flag_z"}, {31'd0, flag_z}, {31'd0, m_fz});
        chk({tag, " flag_n"}, {31'd0, flag_n}, {31'd0, m_fn});
    endtask

    // Call just after a negedge. Leaves in_valid at 'hold' after acceptance.
    task automatic run_op(input string tag, input logic ld, input logic [2:0] opc,
                          input logic cin, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [15:0] imm, input logic hold);
        int n;
        int lat;
        int busy;
        logic [15:0] ea, eb, res;
        in_ld = ld; in_opc = opc; in_cin = cin; in_dst = dst;
        in_srca = sa; in_srcb = sb; in_imm = imm; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, " accept timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ea = m_reg[sa];
        eb = m_reg[sb];
        #1;
        in_valid = hold;
        lat = (ld || opc == 3'b111) ? 1 : int'(EC) + 2;
        busy = 0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                if (!in_ready) busy++;
                chk({tag, " done while busy"}, {31'd0, done}, 32'd0);
                chk({tag, " alu_opc held"}, {29'd0, alu_opc}, {29'd0, opc});
                chk({tag, " alu_a held"}, {16'd0, alu_a}, {16'd0, ea});
                chk({tag, " alu_b held"}, {16'd0, alu_b}, {16'd0, eb});
                chk({tag, " alu_c held"}, {31'd0, alu_c}, {31'd0, cin});
            end
        end
        if (lat > 1) chk({tag, " busy cycles"}, busy, EC + 1);
        chk({tag, " done"}, {31'd0, done}, {31'd0, (ld || opc != 3'b111)});
        chk({tag, " err"}, {31'd0, err}, {31'd0, (!ld && opc == 3'b111)});
        chk({tag, " in_ready after"}, {31'd0, in_ready}, 32'd1);
        if (ld) begin
            m_reg[dst] = imm;
        end else if (opc != 3'b111) begin
            res = alu_f(opc, ea, eb, cin);
            m_reg[dst] = res;
            m_fz = (res == 16'h0000);
            m_fn = res[15];
        end
        check_state(tag);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_reg[i] = RINIT;
        m_fz = 1'b0;
        m_fn = 1'b0;
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset alu_a", {16'd0, alu_a}, 32'd0);
        chk("reset alu_opc", {29'd0, alu_opc}, 32'd0);
        chk("reset done/err", {30'd0, done, err}, 32'd0);
        check_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("ld r0", 1, 3'b000, 0, 2'd0, 2'd0, 2'd0, 16'h0005, 0);
        @(negedge clk);
        chk("load done one cycle", {31'd0, done}, 32'd0);
        run_op("ld r1", 1, 3'b000, 0, 2'd1, 2'd0, 2'd0, 16'h0003, 0);
        run_op("add", 0, 3'b010, 1, 2'd2, 2'd0, 2'd1, 16'h0000, 0);
        chk("add result", {16'd0, m_reg[2]}, 32'h0009);
        @(negedge clk);
        chk("wb done one cycle", {31'd0, done}, 32'd0);
        run_op("neg", 0, 3'b000, 0, 2'd3, 2'd0, 2'd0, 16'h0000, 0);
        run_op("ld r0b", 1, 3'b000, 0, 2'd0, 2'd0, 2'd0, 16'h00F0, 0);
        run_op("ld r1b", 1, 3'b000, 0, 2'd1, 2'd0, 2'd0, 16'h0F00, 0);
        run_op("and", 0, 3'b100, 0, 2'd2, 2'd0, 2'd1, 16'h0000, 0);
        run_op("ld r0c", 1, 3'b000, 0, 2'd0, 2'd0, 2'd0, 16'h1234, 0);
        run_op("ld r1c", 1, 3'b000, 0, 2'd1, 2'd0, 2'd0, 16'hAB56, 0);
        run_op("op110", 0, 3'b110, 0, 2'd3, 2'd0, 2'd1, 16'h0000, 0);
        run_op("illegal", 0, 3'b111, 1, 2'd2, 2'd3, 2'd3, 16'h0000, 0);
        @(negedge clk);
        chk("err one cycle", {30'd0, done, err}, 32'd0);

        // Back-to-back with in_valid held high; includes dst==src.
        run_op("b2b1", 0, 3'b010, 0, 2'd0, 2'd0, 2'd1, 16'h0000, 1);
        run_op("b2b2", 0, 3'b001, 0, 2'd1, 2'd1, 2'd0, 16'h0000, 1);
        run_op("b2b3", 0, 3'b101, 1, 2'd2, 2'd2, 2'd2, 16'h0000, 0);

        for (int k = 0; k < 40; k++) begin
            logic       r_ld;
            logic [2:0] r_opc;
            r_ld  = ($urandom_range(0, 3) == 0);
            r_opc = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d", k), r_ld, r_opc, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Abort an operation mid-EXEC with reset.
        in_valid = 1'b0;
        @(negedge clk);
        in_ld = 1'b0; in_opc = 3'b011; in_dst = 2'd1; in_srca = 2'd2; in_srcb = 2'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) m_reg[i] = RINIT;
        m_fz = 1'b0;
        m_fn = 1'b0;
        chk("abort alu_a", {16'd0, alu_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (EC + 3) @(negedge clk);
        chk("abort no done", {31'd0, done}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        check_state("abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
